afifo_rd_packer: RTL and testbench

//  Read-side consumer for the AFIFO async FIFO; lives in the rclk domain.

---
 rtl/afifo_pkg.sv | 23 ++
 rtl/afifo_rd_packer.sv | 134 +++++++++++++
 tb/tb_afifo_rd_packer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/afifo_pkg.sv
// afifo_pkg
//   Shared definitions for the AFIFO read-side consumer.
//   DATASIZE_DEF : default FIFO entry width (must track the AFIFO build)
//   PACK_MAX     : largest supported lane count; lane_mask() is sized to it
//   rd_state_e   : packer FSM encoding (FILL = 1'b0, HOLD = 1'b1)
//   lane_mask()  : one-hot lane select for a lane index
package afifo_pkg;

  localparam int DATASIZE_DEF = 8;
  localparam int PACK_MAX     = 16;
  localparam int LANE_IDXW    = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } rd_state_e;

  // Callers narrow the result to their own PACK width.
  function automatic logic [PACK_MAX-1:0] lane_mask(input logic [LANE_IDXW-1:0] idx);
    return {{(PACK_MAX-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/afifo_rd_packer.sv
// afifo_rd_packer
//   Read-domain consumer for the AFIFO. Pops one DATASIZE-bit entry per
//   cycle from the show-ahead read port, packs PACK entries little-endian
//   into one word and offers it on a registered valid/ready stream. A flush
//   closes a partially filled word early; unfilled lanes read as zero and
//   out_keep marks which lanes hold real entries.
//
//   Ports
//     rclk, rrst   read clock, asynchronous active-high reset
//     rempty       AFIFO empty flag
//     rdata        AFIFO head entry, valid while rempty is low
//     rpop         pop request to AFIFO (combinational)
//     flush        close the current partial word
//     out_valid    packed word valid (registered)
//     out_ready    downstream accept
//     out_data     packed word, lane i = [i*DATASIZE +: DATASIZE]
//     out_keep     lane i holds a popped entry
//     word_cnt     words delivered since reset, wraps
//     busy         lanes partially filled or a word pending
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   FILL  | popping entries into lanes, word not yet offered
//   HOLD  | word offered; data/keep frozen until out_ready
//
//   PACK is expected to lie in 2..16.
module afifo_rd_packer
  import afifo_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DEF,
  parameter int PACK     = 4,
  parameter int CNTW     = 16
) (
  input  logic                     rclk,
  input  logic                     rrst,
  input  logic                     rempty,
  input  logic [DATASIZE-1:0]      rdata,
  output logic                     rpop,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATASIZE*PACK-1:0] out_data,
  output logic [PACK-1:0]          out_keep,
  output logic [CNTW-1:0]          word_cnt,
  output logic                     busy
);

  localparam int IDXW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(PACK - 1);

  rd_state_e                state_q, state_n;
  logic [IDXW-1:0]          idx_q, idx_n;
  logic [DATASIZE*PACK-1:0] data_q, data_n;
  logic [PACK-1:0]          keep_q, keep_n;
  logic [CNTW-1:0]          cnt_q, cnt_n;
  logic [LANE_IDXW-1:0]     idx_lane;
  logic                     close_word;

  // Reset also gates the pop so AFIFO never loses an entry while we are
  // being cleared.
  assign rpop = (state_q == FILL) && !rempty && !rrst;

  assign idx_lane = LANE_IDXW'(idx_q);

  // A word closes when the last lane is filled, or on flush provided at
  // least one lane will be populated after this edge (an entry popped in
  // the same cycle counts).
  assign close_word = (state_q == FILL) &&
                      ((rpop && (idx_q == LAST_IDX)) ||
                       (flush && (rpop || (idx_q != '0))));

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    data_n  = data_q;
    keep_n  = keep_q;
    cnt_n   = cnt_q;

    case (state_q)
      FILL: begin
        if (rpop) begin
          data_n[int'(idx_q)*DATASIZE +: DATASIZE] = rdata;
          keep_n = keep_q | PACK'(lane_mask(idx_lane));
        end
        if (close_word) begin
          state_n = HOLD;
          idx_n   = '0;
        end else if (rpop) begin
          idx_n = idx_q + IDXW'(1);
        end
      end

      HOLD: begin
        if (out_ready) begin
          state_n = FILL;
          data_n  = '0;
          keep_n  = '0;
          cnt_n   = cnt_q + CNTW'(1);
        end
      end

      default: begin
        state_n = FILL;
        idx_n   = '0;
        data_n  = '0;
        keep_n  = '0;
      end
    endcase
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q <= FILL;
      idx_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      data_q  <= data_n;
      keep_q  <= keep_n;
      cnt_q   <= cnt_n;
    end
  end

  // out_valid is a direct decode of the state flop, so it stays registered.
  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign word_cnt  = cnt_q;
  assign busy      = (idx_q != '0) || out_valid;

endmodule

// File: tb/tb_afifo_rd_packer.sv
module tb_afifo_rd_packer;

  logic        rclk = 1'b0;
  logic        wclk = 1'b0;
  logic        rrst = 1'b0;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rpop;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic [15:0] word_cnt;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  // Show-ahead FIFO model: writes only from the main process at times
  // away from rclk edges, reads advance on rclk when rpop is high.
  logic [7:0] mem [0:63];
  logic [5:0] wr_ptr = '0;
  logic [5:0] rd_ptr = '0;
  int         pop_cnt = 0;
  int         bad_pop = 0;

  logic [31:0] beat_data [$];
  logic [3:0]  beat_keep [$];

  assign rempty = (wr_ptr == rd_ptr);
  assign rdata  = mem[rd_ptr];

  always #20 rclk = ~rclk;
  always #30 wclk = ~wclk;

  afifo_rd_packer #(.DATASIZE(8), .PACK(4), .CNTW(16)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rempty    (rempty),
    .rdata     (rdata),
    .rpop      (rpop),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .word_cnt  (word_cnt),
    .busy      (busy)
  );

  always @(posedge rclk) begin
    if (rpop) begin
      if (rempty) bad_pop <= bad_pop + 1;
      rd_ptr  <= rd_ptr + 6'd1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  // Inputs only change just after a posedge, so a handshake seen at the
  // negedge is the one that completes at the following posedge.
  always @(negedge rclk) begin
    if (out_valid && out_ready) begin
      beat_data.push_back(out_data);
      beat_keep.push_back(out_keep);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_w(input logic [7:0] b);
    @(posedge wclk);
    #1;
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic load_now(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic step;
    @(posedge rclk);
    #1;
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int i = 0; i < budget && beat_data.size() < n; i++) @(negedge rclk);
    chk("beat_count", 64'(beat_data.size()), 64'(n));
  endtask

  task automatic chk_beat(input string tag, input int k, input logic [31:0] d, input logic [3:0] kp);
    if (beat_data.size() > k) begin
      chk({tag, "_data"}, 64'(beat_data[k]), 64'(d));
      chk({tag, "_keep"}, 64'(beat_keep[k]), 64'(kp));
    end else begin
      chk({tag, "_missing"}, 64'(beat_data.size()), 64'(k + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // 1: reset pulse
    #5 rrst = 1'b1;
    #10;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_keep",  64'(out_keep),  64'd0);
    chk("rst_cnt",   64'(word_cnt),  64'd0);
    chk("rst_rpop",  64'(rpop),      64'd0);
    #10 rrst = 1'b0;

    // 2: two full words, downstream always ready
    step();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push_w(8'(i));
    wait_beats(2, 60);
    chk_beat("t2_w0", 0, 32'h04030201, 4'hF);
    chk_beat("t2_w1", 1, 32'h08070605, 4'hF);
    @(negedge rclk);
    @(negedge rclk);
    chk("t2_cnt",    64'(word_cnt), 64'd2);
    chk("t2_empty",  64'(rempty),   64'd1);
    chk("t2_pops",   64'(pop_cnt),  64'd8);
    chk("t2_valid",  64'(out_valid), 64'd0);

    // 3: back-pressure, then a single beat on release
    step();
    out_ready = 1'b0;
    push_w(8'h10); push_w(8'h20); push_w(8'h30); push_w(8'h40);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge rclk);
    chk("t3_valid_up", 64'(out_valid), 64'd1);
    load_now(8'h55);
    for (int i = 0; i < 10; i++) begin
      @(negedge rclk);
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
      chk("t3_hold_data",  64'(out_data),  64'h40302010);
      chk("t3_hold_rpop",  64'(rpop),      64'd0);
    end
    chk("t3_no_beat", 64'(beat_data.size()), 64'd2);
    step();
    out_ready = 1'b1;
    wait_beats(3, 20);
    chk_beat("t3_w", 2, 32'h40302010, 4'hF);
    repeat (3) @(negedge rclk);
    chk("t3_one_beat", 64'(beat_data.size()), 64'd3);
    chk("t3_busy",     64'(busy),             64'd1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_beats(4, 10);
    chk_beat("t3_tail", 3, 32'h00000055, 4'b0001);

    // 4: flush a two-entry word, then flush with nothing captured
    push_w(8'hAA); push_w(8'hBB);
    for (int i = 0; i < 20 && !rempty; i++) @(negedge rclk);
    chk("t4_drained", 64'(rempty), 64'd1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_beats(5, 10);
    chk_beat("t4_w", 4, 32'h0000BBAA, 4'b0011);
    @(negedge rclk);
    chk("t4_idle_busy", 64'(busy), 64'd0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (5) @(negedge rclk);
    chk("t4_empty_flush", 64'(beat_data.size()), 64'd5);
    chk("t4_no_valid",    64'(out_valid),        64'd0);

    // 5: flush on the same cycle as the third pop
    step();
    base = pop_cnt;
    load_now(8'h11); load_now(8'h22); load_now(8'h33);
    step();
    step();
    chk("t5_pops_before", 64'(pop_cnt - base), 64'd2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_beats(6, 10);
    chk_beat("t5_w", 5, 32'h00332211, 4'b0111);

    // 6: reset in the middle of a word
    step();
    load_now(8'hE1); load_now(8'hE2);
    step();
    step();
    rrst = 1'b1;
    load_now(8'hF1); load_now(8'hF2); load_now(8'hF3); load_now(8'hF4);
    #5;
    chk("t6_rst_rpop", 64'(rpop),     64'd0);
    chk("t6_rst_cnt",  64'(word_cnt), 64'd0);
    chk("t6_rst_keep", 64'(out_keep), 64'd0);
    chk("t6_rst_busy", 64'(busy),     64'd0);
    #15 rrst = 1'b0;
    wait_beats(7, 20);
    chk_beat("t6_w", 6, 32'hF4F3F2F1, 4'hF);
    @(negedge rclk);
    @(negedge rclk);
    chk("t6_cnt", 64'(word_cnt), 64'd1);

    chk("bad_pops", 64'(bad_pop), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
